uart_tx_serializer: RTL and testbench

- Transmit serializer for the UART16550 block. It consumes bytes from the TX FIFO inside the UART register bank and drives the serial line stx_pad_o.
- Frames each byte as start, 5–8 data bits LSB first, optional parity, then 1, 1.5 or 2 stop bits.
- Bit timing comes from the 16x baud-rate enable strobe produced by the divisor logic.

---
 rtl/uart_defines.sv | 43 ++++
 rtl/uart_tx_serializer.sv | 122 ++++++++++++
 tb/tb_uart_tx_serializer.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_defines.sv
// Shared definitions for the UART16550 transmit path: state encoding,
// word-length codes, default bit timing and the data-parity helper.
package uart_defines;

  localparam int TICKS_PER_BIT_DEF = 16;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_e;

  // LCR[1:0] word-length codes
  localparam logic [1:0] WLS_5 = 2'd0;
  localparam logic [1:0] WLS_6 = 2'd1;
  localparam logic [1:0] WLS_7 = 2'd2;
  localparam logic [1:0] WLS_8 = 2'd3;

  // Index of the last data bit sent for a given word-length code.
  function automatic logic [2:0] data_last_idx(input logic [1:0] word_len);
    logic [2:0] idx;
    case (word_len)
      WLS_5:   idx = 3'd4;
      WLS_6:   idx = 3'd5;
      WLS_7:   idx = 3'd6;
      default: idx = 3'd7;
    endcase
    return idx;
  endfunction

  // XOR over the data bits actually transmitted.
  function automatic logic data_xor(input logic [7:0] data, input logic [1:0] word_len);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (3'(i) <= data_last_idx(word_len)) acc = acc ^ data[i];
    end
    return acc;
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: pops bytes from the TX FIFO and frames them as
// start / 5-8 data bits LSB first / optional parity / 1, 1.5 or 2 stop bits.
module uart_tx_serializer
  import uart_defines::*;
#(
  parameter int TICKS_PER_BIT = TICKS_PER_BIT_DEF  // even, >= 4
) (
  input  logic       clk,
  input  logic       wb_rst_i,
  input  logic       enable,
  input  logic [1:0] word_len,
  input  logic       stop_bits,
  input  logic       parity_en,
  input  logic       even_parity,
  input  logic       stick_parity,
  input  logic       break_ctrl,
  input  logic [7:0] tf_data_i,
  input  logic       tf_empty_i,
  output logic       tf_pop_o,
  output logic       stx_pad_o,
  output logic       tx_busy_o,
  output logic       tx_idle_o
);

  localparam int TW = $clog2(2 * TICKS_PER_BIT);
  localparam logic [TW-1:0] BIT_LAST    = TW'(TICKS_PER_BIT - 1);
  localparam logic [TW-1:0] STOP15_LAST = TW'(3 * TICKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] STOP2_LAST  = TW'(2 * TICKS_PER_BIT - 1);

  tx_state_e     state_reg;
  logic [TW-1:0] tick_cnt_reg;
  logic [2:0]    bit_cnt_reg;
  logic [7:0]    shift_reg;
  logic [1:0]    word_len_reg;
  logic          stop_bits_reg;
  logic          parity_en_reg;
  logic          parity_bit_reg;
  logic          pop_reg;
  logic          stx_reg;

  logic [TW-1:0] tick_last;
  logic          bit_end;
  logic          line_next;
  logic          parity_next;

  always_comb begin
    tick_last = BIT_LAST;
    if (state_reg == TX_STOP && stop_bits_reg) begin
      tick_last = (word_len_reg == WLS_5) ? STOP15_LAST : STOP2_LAST;
    end
    bit_end = enable && (tick_cnt_reg == tick_last);

    case (state_reg)
      TX_START:  line_next = 1'b0;
      TX_DATA:   line_next = shift_reg[0];
      TX_PARITY: line_next = parity_bit_reg;
      default:   line_next = 1'b1;
    endcase
    if (break_ctrl) line_next = 1'b0;

    // The parity bit is fixed at latch time so later LCR writes cannot alter it.
    parity_next = stick_parity ? ~even_parity
                               : (data_xor(tf_data_i, word_len) ^ ~even_parity);
  end

  always_ff @(posedge clk) begin
    if (wb_rst_i) begin
      state_reg      <= TX_IDLE;
      tick_cnt_reg   <= '0;
      bit_cnt_reg    <= '0;
      shift_reg      <= '0;
      word_len_reg   <= '0;
      stop_bits_reg  <= 1'b0;
      parity_en_reg  <= 1'b0;
      parity_bit_reg <= 1'b0;
      pop_reg        <= 1'b0;
      stx_reg        <= 1'b1;
    end else begin
      pop_reg <= 1'b0;
      stx_reg <= line_next;
      if (state_reg == TX_IDLE) begin
        tick_cnt_reg <= '0;
        if (!tf_empty_i) begin
          pop_reg        <= 1'b1;
          shift_reg      <= tf_data_i;
          word_len_reg   <= word_len;
          stop_bits_reg  <= stop_bits;
          parity_en_reg  <= parity_en;
          parity_bit_reg <= parity_next;
          state_reg      <= TX_START;
        end
      end else if (enable) begin
        if (!bit_end) begin
          tick_cnt_reg <= tick_cnt_reg + TW'(1);
        end else begin
          tick_cnt_reg <= '0;
          case (state_reg)
            TX_START: begin
              bit_cnt_reg <= '0;
              state_reg   <= TX_DATA;
            end
            TX_DATA: begin
              shift_reg   <= {1'b0, shift_reg[7:1]};
              bit_cnt_reg <= bit_cnt_reg + 3'd1;
              if (bit_cnt_reg == data_last_idx(word_len_reg)) begin
                state_reg <= parity_en_reg ? TX_PARITY : TX_STOP;
              end
            end
            TX_PARITY: state_reg <= TX_STOP;
            default:   state_reg <= TX_IDLE;
          endcase
        end
      end
    end
  end

  assign tf_pop_o  = pop_reg;
  assign stx_pad_o = stx_reg;
  assign tx_busy_o = (state_reg != TX_IDLE);
  assign tx_idle_o = (state_reg == TX_IDLE) && tf_empty_i;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboard bench for uart_tx_serializer: a FIFO model feeds bytes, a line
// monitor decodes frames by counting baud ticks and compares with a frame model.
module tb_uart_tx_serializer;

  localparam int TPB = 16;

  logic       clk = 1'b0;
  logic       wb_rst_i;
  logic       enable;
  logic [1:0] word_len;
  logic       stop_bits, parity_en, even_parity, stick_parity, break_ctrl;
  logic [7:0] tf_data_i;
  logic       tf_empty_i;
  logic       tf_pop_o, stx_pad_o, tx_busy_o, tx_idle_o;

  always #5 clk = ~clk;

  uart_tx_serializer #(.TICKS_PER_BIT(TPB)) dut (
    .clk(clk), .wb_rst_i(wb_rst_i), .enable(enable), .word_len(word_len),
    .stop_bits(stop_bits), .parity_en(parity_en), .even_parity(even_parity),
    .stick_parity(stick_parity), .break_ctrl(break_ctrl), .tf_data_i(tf_data_i),
    .tf_empty_i(tf_empty_i), .tf_pop_o(tf_pop_o), .stx_pad_o(stx_pad_o),
    .tx_busy_o(tx_busy_o), .tx_idle_o(tx_idle_o)
  );

  typedef struct {
    logic [7:0] data;
    int         nbits;
    bit         has_par;
    bit         par;
    int         stop_ticks;
  } frame_t;

  frame_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  // FIFO model (first-word-fall-through)
  logic [7:0] fifo_mem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign tf_empty_i = (wr_ptr == rd_ptr);
  assign tf_data_i  = fifo_mem[rd_ptr[5:0]];
  always @(posedge clk) if (tf_pop_o && !tf_empty_i) rd_ptr <= rd_ptr + 1;

  // Baud tick generator: one strobe every en_div clocks
  int en_div = 1;
  int en_phase = 0;
  logic en_q = 1'b0;
  initial begin
    enable = 1'b0;
    forever begin
      @(negedge clk);
      en_phase++;
      if (en_phase >= en_div) en_phase = 0;
      enable = (en_phase == 0);
    end
  end
  always @(posedge clk) en_q <= enable;

  function automatic frame_t model(input logic [7:0] d, input int wl, input bit sb,
                                   input bit pen, input bit eps, input bit sp);
    frame_t f;
    int ones;
    f.data = d;
    f.nbits = wl + 5;
    ones = 0;
    for (int i = 0; i < f.nbits; i++) ones += int'(d[i]);
    f.has_par = pen;
    f.par = sp ? !eps : (eps ? (ones % 2 == 1) : (ones % 2 == 0));
    f.stop_ticks = !sb ? TPB : ((wl == 0) ? 3 * TPB / 2 : 2 * TPB);
    return f;
  endfunction

  // Pop accounting and pop-while-empty check
  int cyc = 0, pops = 0, busy_cycles = 0, last_pop_cyc = 0, prev_pop_cyc = 0;
  always @(negedge clk) begin
    cyc++;
    if (tx_busy_o) busy_cycles++;
    if (tf_pop_o) begin
      pops++;
      prev_pop_cyc = last_pop_cyc;
      last_pop_cyc = cyc;
      vectors++;
      if (tf_empty_i) begin
        miscompares++;
        $display("FAIL pop_when_empty: tf_pop_o=1 at cycle %0d with empty FIFO, required 0", cyc);
      end
    end
  end

  // Line monitor: sample each bit mid-way in ticks, check stop level over its span
  bit mon_en = 1'b0;
  bit mon_active = 1'b0;
  frame_t cur;
  int j = 0, frames = 0;
  logic [11:0] got_lv, exp_lv;
  bit stop_ok;
  logic stx_prev = 1'b1;
  always @(negedge clk) begin
    int nseg, total, s;
    if (!mon_en) begin
      mon_active = 1'b0;
    end else if (!mon_active && stx_prev && !stx_pad_o) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_frame: start bit at cycle %0d, required no frame", cyc);
      end else begin
        cur = exp_q.pop_front();
        mon_active = 1'b1;
        j = 0;
        got_lv = '0;
        stop_ok = 1'b1;
      end
    end
    if (mon_en && mon_active && en_q) begin
      nseg = 1 + cur.nbits + (cur.has_par ? 1 : 0);
      total = nseg * TPB + cur.stop_ticks - 1;
      if (j < nseg * TPB) begin
        if (j % TPB == TPB / 2) got_lv[j / TPB] = stx_pad_o;
      end else begin
        s = j - nseg * TPB;
        if (s >= 1 && stx_pad_o !== 1'b1) stop_ok = 1'b0;
      end
      j++;
      if (j == total) begin
        exp_lv = '0;
        for (int i = 0; i < cur.nbits; i++) exp_lv[1 + i] = cur.data[i];
        if (cur.has_par) exp_lv[1 + cur.nbits] = cur.par;
        vectors++;
        frames++;
        if (got_lv !== exp_lv || !stop_ok) begin
          miscompares++;
          $display("FAIL frame%0d data=%02h bits=%0d: line bits %03h stop_ok=%0d, required bits %03h stop_ok=1",
                   frames, cur.data, cur.nbits, got_lv, stop_ok, exp_lv);
        end else begin
          $display("frame%0d data=%02h bits=%0d par=%0d/%0d stop=%0d ticks ok",
                   frames, cur.data, cur.nbits, cur.has_par, cur.par, cur.stop_ticks);
        end
        mon_active = 1'b0;
      end
    end
    stx_prev = stx_pad_o;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    vectors++;
    if (got !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d required %0d", name, got, req);
    end else begin
      $display("check %s = %0d ok", name, got);
    end
  endtask

  task automatic check_range(input string name, input int got, input int lo, input int hi);
    vectors++;
    if (got < lo || got > hi) begin
      miscompares++;
      $display("FAIL %s: got %0d required %0d..%0d", name, got, lo, hi);
    end else begin
      $display("check %s = %0d ok", name, got);
    end
  endtask

  task automatic set_cfg(input int wl, input bit sb, input bit pen, input bit eps, input bit sp);
    word_len = 2'(wl);
    stop_bits = sb;
    parity_en = pen;
    even_parity = eps;
    stick_parity = sp;
  endtask

  task automatic fifo_write(input logic [7:0] d);
    fifo_mem[wr_ptr[5:0]] = d;
    wr_ptr++;
  endtask

  task automatic send_now(input logic [7:0] d);
    @(negedge clk);
    exp_q.push_back(model(d, int'(word_len), stop_bits, parity_en, even_parity, stick_parity));
    fifo_write(d);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || mon_active || !tx_idle_o) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: %0d frames pending after %0d clk, required 0", exp_q.size(), budget);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, p0, n, d, grp;
    bit brk_ok;
    for (int i = 0; i < 64; i++) fifo_mem[i] = 8'h00;
    wb_rst_i = 1'b1;
    break_ctrl = 1'b0;
    set_cfg(3, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    check("rst_stx", stx_pad_o, 1);
    check("rst_pop", tf_pop_o, 0);
    check("rst_busy", tx_busy_o, 0);
    check("rst_idle", tx_idle_o, 1);
    wb_rst_i = 1'b0;
    mon_en = 1'b1;

    // 8N1, one tick per clk
    en_div = 1;
    b0 = busy_cycles;
    p0 = pops;
    send_now(8'h55);
    wait_drain(400);
    check("8n1_busy_clk", busy_cycles - b0, 160);
    check("8n1_pops", pops - p0, 1);

    // 7-bit parity: even, odd, stick with EPS=1
    set_cfg(2, 0, 1, 1, 0); send_now(8'h41); wait_drain(400);
    set_cfg(2, 0, 1, 0, 0); send_now(8'h41); wait_drain(400);
    set_cfg(2, 0, 1, 1, 1); send_now(8'h41); wait_drain(400);

    // 5-bit, 1.5 stop, enable every 4th clk, two frames back to back
    en_div = 4;
    set_cfg(0, 1, 0, 0, 0);
    send_now(8'h1F);
    send_now(8'h1F);
    wait_drain(2000);
    check_range("5n15_pop_spacing", last_pop_cyc - prev_pop_cyc, 4 * 120 - 3, 4 * 120 + 8);

    // Back-to-back 8N2 with a word_len change during frame 1
    en_div = 1;
    set_cfg(3, 1, 0, 0, 0);
    p0 = pops;
    @(negedge clk);
    exp_q.push_back(model(8'hA5, 3, 1, 0, 0, 0));
    exp_q.push_back(model(8'h3C, 1, 1, 0, 0, 0));
    fifo_write(8'hA5);
    fifo_write(8'h3C);
    repeat (60) @(negedge clk);
    word_len = 2'd1;
    wait_drain(1000);
    check("b2b_pops", pops - p0, 2);
    d = last_pop_cyc - prev_pop_cyc;
    check_range("b2b_pop_spacing", d, 176, 178);

    // Randomized configurations and bursts
    for (grp = 0; grp < 15; grp++) begin
      en_div = int'($urandom_range(1, 2));
      set_cfg(int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      n = int'($urandom_range(1, 3));
      for (int k = 0; k < n; k++) send_now(8'($urandom));
      wait_drain(4000);
    end

    // Break during a frame
    en_div = 1;
    set_cfg(3, 0, 1, 0, 0);
    mon_en = 1'b0;
    @(negedge clk);
    fifo_write(8'h5A);
    repeat (40) @(negedge clk);
    break_ctrl = 1'b1;
    @(negedge clk);
    brk_ok = 1'b1;
    n = 0;
    while (!tx_idle_o && n < 1000) begin
      if (stx_pad_o !== 1'b0) brk_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    check("brk_line_low", brk_ok, 1);
    check("brk_idle", tx_idle_o, 1);
    check("brk_hold", stx_pad_o, 0);
    break_ctrl = 1'b0;
    @(negedge clk);
    check("brk_release", stx_pad_o, 1);
    mon_en = 1'b1;

    // Reset in the middle of a frame with another byte waiting
    mon_en = 1'b0;
    @(negedge clk);
    fifo_write(8'h33);
    repeat (40) @(negedge clk);
    exp_q.push_back(model(8'hC6, int'(word_len), stop_bits, parity_en, even_parity, stick_parity));
    fifo_write(8'hC6);
    p0 = pops;
    wb_rst_i = 1'b1;
    @(negedge clk);
    check("rstmid_stx", stx_pad_o, 1);
    check("rstmid_busy", tx_busy_o, 0);
    check("rstmid_pop", tf_pop_o, 0);
    wb_rst_i = 1'b0;
    mon_en = 1'b1;
    wait_drain(400);
    check("rstmid_pops", pops - p0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
